ysyx_25030093_ifu: RTL and testbench

YSYX_25030093_IFU -- requirements
Module: ysyx_25030093_ifu

---
 rtl/ysyx_25030093_pkg.sv | 26 ++
 rtl/ysyx_25030093_ifu.sv | 160 ++++++++++++++++
 tb/tb_ysyx_25030093_ifu.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_25030093_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_25030093_pkg
//  Purpose  : Shared definitions for the instruction fetch unit: FSM state
//             encoding, the fault-substitute instruction word and the AXI
//             read-response OKAY code.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package ysyx_25030093_pkg;

  // Fetch FSM states.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,  // waiting for a fetch address
    S_AR   = 2'd1,  // driving the read address
    S_R    = 2'd2,  // waiting for read data
    S_HOLD = 2'd3   // presenting the instruction to decode
  } ifu_state_e;

  // addi x0, x0, 0 -- harmless filler delivered on any fetch fault.
  localparam logic [31:0] NOP_INST   = 32'h00000013;

  localparam logic [1:0]  RRESP_OKAY = 2'b00;

endpackage : ysyx_25030093_pkg
`default_nettype wire

// File: rtl/ysyx_25030093_ifu.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_25030093_ifu
//  Purpose  : Instruction fetch unit. Accepts a fetch address from the PC
//             unit, performs one AXI-style read (AR then R channel) and
//             holds the returned instruction until decode consumes it.
//             Misaligned addresses and bus errors yield NOP_INST with the
//             fault bit set. A flush discards the in-flight or held fetch.
//  Ports    : clk, rst                  - clock, sync active-high reset
//             pc_in/pc_valid/pc_ready   - fetch address handshake
//             araddr/arvalid/arready    - read address channel
//             rdata/rresp/rvalid/rready - read data channel
//             inst/inst_pc/inst_fault/inst_valid/inst_ready - to decode
//             flush                     - redirect, drop current fetch
//             fetch_cnt                 - delivered instruction count
//  Revision : 1.0 - initial release
// ============================================================================
module ysyx_25030093_ifu #(
  parameter logic [31:0] NOP_INST = ysyx_25030093_pkg::NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  // PC unit
  input  logic [31:0] pc_in,
  input  logic        pc_valid,
  output logic        pc_ready,
  // read address channel
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  // read data channel
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  // decode
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_fault,
  output logic        inst_valid,
  input  logic        inst_ready,
  // control / status
  input  logic        flush,
  output logic [31:0] fetch_cnt
);

  import ysyx_25030093_pkg::*;

  ifu_state_e  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        fault_q, fault_d;
  // Set by a flush while a bus transaction is outstanding; the transaction
  // still completes on the bus but its data is thrown away.
  logic        discard_q, discard_d;
  logic [31:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pc_q      <= 32'd0;
      inst_q    <= NOP_INST;
      fault_q   <= 1'b0;
      discard_q <= 1'b0;
      cnt_q     <= 32'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      fault_q   <= fault_d;
      discard_q <= discard_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    fault_d   = fault_q;
    discard_d = discard_q;
    cnt_d     = cnt_q;

    case (state_q)
      S_IDLE: begin
        // flush is deliberately ignored here: nothing is in flight.
        if (pc_valid) begin
          pc_d = pc_in;
          if (pc_in[1:0] != 2'b00) begin
            // Misaligned: never touch the bus, report the fault directly.
            inst_d  = NOP_INST;
            fault_d = 1'b1;
            state_d = S_HOLD;
          end else begin
            state_d = S_AR;
          end
        end
      end

      S_AR: begin
        // arvalid is never retracted; a flush only marks the result dead.
        if (flush) begin
          discard_d = 1'b1;
        end
        if (arready) begin
          state_d = S_R;
        end
      end

      S_R: begin
        if (rvalid) begin
          if (discard_q || flush) begin
            // Beat consumed but dropped; skip HOLD so nothing is counted.
            discard_d = 1'b0;
            state_d   = S_IDLE;
          end else begin
            if (rresp == RRESP_OKAY) begin
              inst_d  = rdata;
              fault_d = 1'b0;
            end else begin
              inst_d  = NOP_INST;
              fault_d = 1'b1;
            end
            state_d = S_HOLD;
          end
        end else if (flush) begin
          discard_d = 1'b1;
        end
      end

      S_HOLD: begin
        // flush takes priority over a simultaneous consume.
        if (flush) begin
          state_d = S_IDLE;
        end else if (inst_ready) begin
          state_d = S_IDLE;
          cnt_d   = cnt_q + 32'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Handshake outputs decode straight from the state register.
  assign pc_ready   = (state_q == S_IDLE);
  assign arvalid    = (state_q == S_AR);
  assign rready     = (state_q == S_R);
  assign inst_valid = (state_q == S_HOLD);

  assign araddr     = pc_q;
  assign inst_pc    = pc_q;
  assign inst       = inst_q;
  assign inst_fault = fault_q;
  assign fetch_cnt  = cnt_q;

endmodule : ysyx_25030093_ifu
`default_nettype wire

// File: tb/tb_ysyx_25030093_ifu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ysyx_25030093_ifu
//  Purpose  : Self-checking bench for the instruction fetch unit. The bench
//             plays both PC unit and memory, cycle by cycle, and keeps a
//             queue of expected instructions that is consumed when decode
//             accepts one.
//  Ports    : none (top-level bench)
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_25030093_ifu;

  localparam logic [31:0] C_NOP = 32'h00000013;

  // flush placement for a fetch
  localparam int FL_NONE = 0;
  localparam int FL_IDLE = 1;  // flush together with pc_valid in IDLE
  localparam int FL_AR   = 2;  // flush during first AR cycle
  localparam int FL_R    = 3;  // flush in R before the beat
  localparam int FL_BEAT = 4;  // flush on the rvalid beat
  localparam int FL_HOLD = 5;  // flush together with inst_ready

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        fault;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [31:0] pc_in;
  logic        pc_valid;
  logic        pc_ready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_fault;
  logic        inst_valid;
  logic        inst_ready;
  logic        flush;
  logic [31:0] fetch_cnt;

  exp_t        sb[$];
  logic [31:0] cnt_exp;
  int          n_total;
  int          n_bad;

  ysyx_25030093_ifu u_dut (
    .clk        (clk),
    .rst        (rst),
    .pc_in      (pc_in),
    .pc_valid   (pc_valid),
    .pc_ready   (pc_ready),
    .araddr     (araddr),
    .arvalid    (arvalid),
    .arready    (arready),
    .rdata      (rdata),
    .rresp      (rresp),
    .rvalid     (rvalid),
    .rready     (rready),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_fault (inst_fault),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .flush      (flush),
    .fetch_cnt  (fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // One complete fetch. Called and returns at a negedge with the DUT in IDLE.
  // Inputs are changed at negedges; outputs are sampled at negedges.
  task automatic fetch(input logic [31:0] pc, input int arw, input int rw,
                       input logic [1:0] resp, input logic [31:0] word,
                       input int holdw, input int fl);
    exp_t e;
    bit   mis;
    bit   killed;
    mis    = (pc[1:0] != 2'b00);
    killed = 1'b0;
    check("idle_pc_ready", {31'd0, pc_ready}, 32'd1);
    pc_in    = pc;
    pc_valid = 1'b1;
    flush    = (fl == FL_IDLE);
    @(negedge clk);
    pc_valid = 1'b0;
    flush    = 1'b0;
    if (!mis) begin
      for (int i = 0; i <= arw; i++) begin
        check("ar_arvalid", {31'd0, arvalid}, 32'd1);
        check("ar_araddr", araddr, pc);
        check("ar_no_inst", {31'd0, inst_valid}, 32'd0);
        arready = (i == arw);
        flush   = (fl == FL_AR) && (i == 0);
        @(negedge clk);
        arready = 1'b0;
        flush   = 1'b0;
      end
      for (int i = 0; i <= rw; i++) begin
        check("r_rready", {31'd0, rready}, 32'd1);
        check("r_no_ar", {31'd0, arvalid}, 32'd0);
        check("r_no_inst", {31'd0, inst_valid}, 32'd0);
        rvalid = (i == rw);
        rdata  = (i == rw) ? word : 32'hDEADBEEF;
        rresp  = resp;
        flush  = ((fl == FL_R) && (i == 0)) || ((fl == FL_BEAT) && (i == rw));
        @(negedge clk);
        rvalid = 1'b0;
        flush  = 1'b0;
      end
      killed = (fl == FL_AR) || (fl == FL_R) || (fl == FL_BEAT);
    end
    if (killed) begin
      check("kill_no_inst", {31'd0, inst_valid}, 32'd0);
    end else begin
      e.inst  = (mis || resp != 2'b00) ? C_NOP : word;
      e.pc    = pc;
      e.fault = mis || (resp != 2'b00);
      sb.push_back(e);
      for (int i = 0; i <= holdw; i++) begin
        check("hold_valid", {31'd0, inst_valid}, 32'd1);
        check("hold_no_ar", {31'd0, arvalid}, 32'd0);
        check("hold_no_pc_ready", {31'd0, pc_ready}, 32'd0);
        if (sb.size() == 0) begin
          check("sb_nonempty", 32'd0, 32'd1);
        end else begin
          check("inst", inst, sb[0].inst);
          check("inst_pc", inst_pc, sb[0].pc);
          check("inst_fault", {31'd0, inst_fault}, {31'd0, sb[0].fault});
        end
        inst_ready = (i == holdw);
        flush      = (fl == FL_HOLD) && (i == holdw);
        if (i == holdw) begin
          if (sb.size() != 0) void'(sb.pop_front());
          if (fl != FL_HOLD) cnt_exp++;
        end
        @(negedge clk);
        inst_ready = 1'b0;
        flush      = 1'b0;
      end
    end
    check("back_idle", {31'd0, pc_ready}, 32'd1);
    check("fetch_cnt", fetch_cnt, cnt_exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_total    = 0;
    n_bad      = 0;
    cnt_exp    = 32'd0;
    rst        = 1'b1;
    pc_in      = 32'd0;
    pc_valid   = 1'b0;
    arready    = 1'b0;
    rdata      = 32'd0;
    rresp      = 2'b00;
    rvalid     = 1'b0;
    inst_ready = 1'b0;
    flush      = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // reset state
    check("rst_pc_ready", {31'd0, pc_ready}, 32'd1);
    check("rst_arvalid", {31'd0, arvalid}, 32'd0);
    check("rst_rready", {31'd0, rready}, 32'd0);
    check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_inst", inst, C_NOP);
    check("rst_fault", {31'd0, inst_fault}, 32'd0);
    check("rst_inst_pc", inst_pc, 32'd0);
    check("rst_cnt", fetch_cnt, 32'd0);

    // zero-wait fetch
    fetch(32'h80000000, 0, 0, 2'b00, 32'h00000297, 0, FL_NONE);
    // wait states, instruction held 4 cycles
    fetch(32'h80000004, 2, 3, 2'b00, 32'h00100093, 4, FL_NONE);
    // misaligned
    fetch(32'h80000002, 0, 0, 2'b00, 32'h12345678, 1, FL_NONE);
    // bus error
    fetch(32'h80000008, 1, 0, 2'b10, 32'hCAFEF00D, 0, FL_NONE);
    // flush while waiting for rvalid
    fetch(32'h8000000C, 0, 2, 2'b00, 32'h11111111, 0, FL_R);
    // flush on the rvalid beat
    fetch(32'h80000010, 0, 1, 2'b00, 32'h22222222, 0, FL_BEAT);
    // flush during AR
    fetch(32'h80000014, 2, 1, 2'b00, 32'h33333333, 0, FL_AR);
    // flush in HOLD together with inst_ready
    fetch(32'h80000018, 0, 0, 2'b00, 32'h44444444, 1, FL_HOLD);
    // flush in IDLE has no effect
    fetch(32'h8000001C, 0, 0, 2'b00, 32'h55555555, 0, FL_IDLE);

    // randomized wait states, occasional error response
    for (int k = 0; k < 8; k++) begin
      fetch(32'h80001000 + 32'(k * 4), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            ($urandom_range(0, 3) == 0) ? 2'b11 : 2'b00, $urandom, int'($urandom_range(0, 2)),
            FL_NONE);
    end

    // reset in R, then a stray rvalid must be ignored
    pc_in    = 32'h80002000;
    pc_valid = 1'b1;
    @(negedge clk);
    pc_valid = 1'b0;
    arready  = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    check("midr_rready", {31'd0, rready}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst     = 1'b0;
    cnt_exp = 32'd0;
    sb.delete();
    check("midr_pc_ready", {31'd0, pc_ready}, 32'd1);
    check("midr_rready_low", {31'd0, rready}, 32'd0);
    check("midr_inst", inst, C_NOP);
    check("midr_fault", {31'd0, inst_fault}, 32'd0);
    check("midr_cnt", fetch_cnt, cnt_exp);
    rvalid = 1'b1;
    rdata  = 32'h66666666;
    rresp  = 2'b00;
    @(negedge clk);
    rvalid = 1'b0;
    check("stray_pc_ready", {31'd0, pc_ready}, 32'd1);
    check("stray_rready", {31'd0, rready}, 32'd0);
    check("stray_inst_valid", {31'd0, inst_valid}, 32'd0);
    check("stray_inst", inst, C_NOP);
    @(negedge clk);
    check("stray_still_idle", {31'd0, inst_valid}, 32'd0);

    // normal operation after the reset
    fetch(32'h80003000, 0, 0, 2'b00, 32'h00000297, 0, FL_NONE);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_ysyx_25030093_ifu
`default_nettype wire
